// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Width of an owner index; at least one bit even for a single requester.
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int count_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after i_ptr.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = owner_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  // Scan from the farthest candidate back to i_ptr so the nearest hit wins.
  always_comb begin
    logic [IW:0] w_sum;
    // NOTE: every output and temporary gets a default before the loop so no path leaves one unassigned.
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
      if (w_sum >= (IW + 1)'(N)) begin
        w_sum = w_sum - (IW + 1)'(N);
      end
      if (i_req[w_sum[IW-1:0]]) begin
        o_idx   = w_sum[IW-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// N-to-1 round-robin arbiter in front of one pipelined Wishbone B4 target.
// The grant lasts a whole CYC (longer while the owner holds LOCK), and the
// number of accepted-but-unterminated strobes is capped at MaxOutstanding.
module wishbone_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NumInitiators  = 4,
  parameter  int AddressWidth   = 16,
  parameter  int DataWidth      = 8,
  parameter  int Granularity    = 8,
  parameter  int MaxOutstanding = 4,
  localparam int SelWidth       = DataWidth / Granularity,
  localparam int OwnerW         = owner_width(NumInitiators)
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [NumInitiators-1:0]          I_CYC,
  input  logic [NumInitiators-1:0]          I_STB,
  input  logic [NumInitiators-1:0]          I_LOCK,
  input  logic [NumInitiators-1:0]          I_WE,
  input  logic [NumInitiators*AddressWidth-1:0] I_ADDR,
  input  logic [NumInitiators*SelWidth-1:0] I_SEL,
  input  logic [NumInitiators*DataWidth-1:0] I_DAT_ToTarget,
  output logic [NumInitiators-1:0]          I_ACK,
  output logic [NumInitiators-1:0]          I_ERR,
  output logic [NumInitiators-1:0]          I_RTY,
  output logic [NumInitiators-1:0]          I_STALL,
  output logic [DataWidth-1:0]              I_DAT_ToInitiator,
  output logic                              T_CYC,
  output logic                              T_STB,
  output logic                              T_LOCK,
  output logic                              T_WE,
  output logic [AddressWidth-1:0]           T_ADDR,
  output logic [SelWidth-1:0]               T_SEL,
  output logic [DataWidth-1:0]              T_DAT_ToTarget,
  input  logic                              T_ACK,
  input  logic                              T_ERR,
  input  logic                              T_RTY,
  input  logic                              T_STALL,
  input  logic [DataWidth-1:0]              T_DAT_ToInitiator,
  output logic [OwnerW-1:0]                 Owner,
  output logic                              OwnerValid
);

  localparam int CountWidth = count_width(MaxOutstanding);

  arb_state_t              r_state;
  logic [OwnerW-1:0]       r_owner;
  logic                    r_owner_valid;
  logic [OwnerW-1:0]       r_ptr;
  logic [CountWidth-1:0]   r_cnt;

  logic [OwnerW-1:0]       w_pick_idx;
  logic                    w_pick_valid;
  logic [OwnerW-1:0]       w_next_ptr;
  logic                    w_granted;
  logic                    w_full;
  logic                    w_t_cyc;
  logic                    w_inc;
  logic                    w_dec;
  logic                    w_term;
  logic [NumInitiators-1:0] w_owner_oh;

  logic                    w_own_cyc;
  logic                    w_own_stb;
  logic                    w_own_lock;
  logic                    w_own_we;
  logic [AddressWidth-1:0] w_own_addr;
  logic [SelWidth-1:0]     w_own_sel;
  logic [DataWidth-1:0]    w_own_dat;

  wb_rr_picker #(
    .N(NumInitiators)
  ) u_picker (
    .i_req   (I_CYC),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_granted  = (r_state == ARB_GRANT);
  assign w_full     = (r_cnt == CountWidth'(MaxOutstanding));
  assign w_owner_oh = {{(NumInitiators-1){1'b0}}, 1'b1} << r_owner;
  assign w_next_ptr = (r_owner == OwnerW'(NumInitiators - 1)) ? '0 : r_owner + 1'b1;

  // Select the current owner's request signals.
  always_comb begin
    w_own_cyc  = 1'b0;
    w_own_stb  = 1'b0;
    w_own_lock = 1'b0;
    w_own_we   = 1'b0;
    w_own_addr = '0;
    w_own_sel  = '0;
    w_own_dat  = '0;
    for (int k = 0; k < NumInitiators; k++) begin
      if (r_owner == OwnerW'(k)) begin
        w_own_cyc  = I_CYC[k];
        w_own_stb  = I_STB[k];
        w_own_lock = I_LOCK[k];
        w_own_we   = I_WE[k];
        w_own_addr = I_ADDR[k*AddressWidth +: AddressWidth];
        w_own_sel  = I_SEL[k*SelWidth +: SelWidth];
        w_own_dat  = I_DAT_ToTarget[k*DataWidth +: DataWidth];
      end
    end
  end

  assign w_t_cyc = w_granted & w_own_cyc;
  assign w_term  = T_ACK | T_ERR | T_RTY;
  assign w_inc   = T_STB & ~T_STALL;
  assign w_dec   = w_t_cyc & w_term;

  // Drive the target bus from the owner; everything is quiet outside an open cycle.
  always_comb begin
    T_CYC          = w_t_cyc;
    T_STB          = w_t_cyc & w_own_stb & ~w_full;
    T_LOCK         = w_granted & w_own_lock;
    T_WE           = w_t_cyc & w_own_we;
    T_ADDR         = w_t_cyc ? w_own_addr : '0;
    T_SEL          = w_t_cyc ? w_own_sel  : '0;
    T_DAT_ToTarget = w_t_cyc ? w_own_dat  : '0;
  end

  // Route stall and terminations back to the owner only; a dropped CYC discards terminations.
  always_comb begin
    I_STALL           = ~(w_owner_oh & {NumInitiators{w_granted & ~(T_STALL | w_full)}});
    I_ACK             = w_owner_oh & {NumInitiators{w_t_cyc & T_ACK}};
    I_ERR             = w_owner_oh & {NumInitiators{w_t_cyc & T_ERR}};
    I_RTY             = w_owner_oh & {NumInitiators{w_t_cyc & T_RTY}};
    I_DAT_ToInitiator = T_DAT_ToInitiator;
  end

  // Grant FSM: pick round-robin in IDLE, hold through CYC and LOCK in GRANT.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: non-blocking assignments so every register here updates from pre-edge values.
    if (!RST_N) begin
      r_state       <= ARB_IDLE;
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_ptr         <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_state       <= ARB_GRANT;
            r_owner       <= w_pick_idx;
            r_owner_valid <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (!w_own_cyc && !w_own_lock) begin
            r_state       <= ARB_IDLE;
            r_owner_valid <= 1'b0;
            r_ptr         <= w_next_ptr;
          end
        end
        default: begin
          r_state       <= ARB_IDLE;
          r_owner_valid <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding-strobe counter; cleared whenever the owner's cycle is not open (abort).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (!w_t_cyc) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (w_dec && !w_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign Owner      = r_owner;
  assign OwnerValid = r_owner_valid;

  // A termination with nothing outstanding means the target is misbehaving.
  a_no_underflow : assert property (@(posedge CLK) disable iff (!RST_N)
    !(w_dec && !w_inc && (r_cnt == '0)));

endmodule
